// File: rtl/cmp_serial.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle.
// Signed operands are compared as offset-binary by flipping the MSB at load.
module cmp_serial #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic             result
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] msbMask = WIDTH'(1) << (WIDTH - 1);
    localparam bit earlyExit = (EARLY_EXIT != 0);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t stateQ;
    state_t stateD;

    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic [2:0]       modeQ;
    logic             gtQ;
    logic             ltQ;
    logic [CW-1:0]    cntQ;
    logic             doneQ;
    logic             resultQ;

    logic [DIGIT-1:0] aDig;
    logic [DIGIT-1:0] bDig;
    logic             undecided;
    logic             gtNext;
    logic             ltNext;
    logic             hitNow;
    logic             finish;
    logic             resNext;

    assign aDig      = aSh[WIDTH-1 -: DIGIT];
    assign bDig      = bSh[WIDTH-1 -: DIGIT];
    assign undecided = !gtQ && !ltQ;
    assign gtNext    = gtQ || (undecided && (aDig > bDig));
    assign ltNext    = ltQ || (undecided && (aDig < bDig));
    assign hitNow    = undecided && (aDig != bDig);
    assign finish    = (stateQ == SCAN) &&
                       ((cntQ == CW'(1)) || (earlyExit && hitNow));

    always_comb begin
        resNext = 1'b0;
        case (modeQ)
            3'd0:    resNext = !gtNext;
            3'd1:    resNext = ltNext;
            3'd2:    resNext = !ltNext;
            3'd3:    resNext = gtNext;
            3'd4:    resNext = !gtNext && !ltNext;
            3'd5:    resNext = gtNext || ltNext;
            default: resNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (start) stateD = SCAN;
            SCAN:    if (finish) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        busy   = (stateQ == SCAN);
        done   = doneQ;
        result = resultQ;
    end

    // Flags become sticky: the first differing digit decides the order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aSh     <= '0;
            bSh     <= '0;
            modeQ   <= '0;
            gtQ     <= 1'b0;
            ltQ     <= 1'b0;
            cntQ    <= '0;
            doneQ   <= 1'b0;
            resultQ <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        aSh   <= a ^ (sgn ? msbMask : '0);
                        bSh   <= b ^ (sgn ? msbMask : '0);
                        modeQ <= mode;
                        gtQ   <= 1'b0;
                        ltQ   <= 1'b0;
                        cntQ  <= CW'(N);
                    end
                end
                SCAN: begin
                    gtQ  <= gtNext;
                    ltQ  <= ltNext;
                    aSh  <= aSh << DIGIT;
                    bSh  <= bSh << DIGIT;
                    cntQ <= cntQ - CW'(1);
                    if (finish) begin
                        doneQ   <= 1'b1;
                        resultQ <= resNext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_serial.sv
// Bench for cmp_serial: three instances (bit-serial, bit-serial early-exit,
// nibble-serial) share stimulus and are checked against an abstract model.
module tb_cmp_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] mode;
    logic       sgn;
    logic       busyO [3];
    logic       doneO [3];
    logic       resO  [3];

    cmp_serial #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .mode(mode), .sgn(sgn),
        .busy(busyO[0]), .done(doneO[0]), .result(resO[0])
    );
    cmp_serial #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .mode(mode), .sgn(sgn),
        .busy(busyO[1]), .done(doneO[1]), .result(resO[1])
    );
    cmp_serial #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(0)) u2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .mode(mode), .sgn(sgn),
        .busy(busyO[2]), .done(doneO[2]), .result(resO[2])
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string nm, input int got, input int exp);
        nCmp++;
        if (got != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int digitOf(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic bit relation(input logic [7:0] x, input logic [7:0] y,
                                    input logic [2:0] m, input logic s);
        int xv;
        int yv;
        xv = s ? int'($signed(x)) : int'(x);
        yv = s ? int'($signed(y)) : int'(y);
        case (m)
            3'd0:    return xv <= yv;
            3'd1:    return xv < yv;
            3'd2:    return xv >= yv;
            3'd3:    return xv > yv;
            3'd4:    return xv == yv;
            3'd5:    return xv != yv;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int latency(input logic [7:0] x, input logic [7:0] y,
                                   input int i);
        int dg;
        int n;
        int msk;
        dg  = digitOf(i);
        n   = 8 / dg;
        msk = (1 << dg) - 1;
        if (i != 1) return n;
        for (int k = 0; k < n; k++) begin
            if (((int'(x) >> (8 - dg * (k + 1))) & msk) !=
                ((int'(y) >> (8 - dg * (k + 1))) & msk))
                return k + 1;
        end
        return n;
    endfunction

    bit mBusy [3] = '{0, 0, 0};
    bit mDone [3] = '{0, 0, 0};
    bit mRes  [3] = '{0, 0, 0};
    bit mPend [3] = '{0, 0, 0};
    int mLeft [3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mBusy[i] <= 1'b0;
                mDone[i] <= 1'b0;
                mRes[i]  <= 1'b0;
                mLeft[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                mDone[i] <= 1'b0;
                if (mBusy[i]) begin
                    mLeft[i] <= mLeft[i] - 1;
                    if (mLeft[i] == 1) begin
                        mBusy[i] <= 1'b0;
                        mDone[i] <= 1'b1;
                        mRes[i]  <= mPend[i];
                    end
                end else if (start) begin
                    mBusy[i] <= 1'b1;
                    mLeft[i] <= latency(a, b, i);
                    mPend[i] <= relation(a, b, mode, sgn);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), int'(busyO[i]), int'(mBusy[i]));
            chk($sformatf("done%0d", i), int'(doneO[i]), int'(mDone[i]));
            chk($sformatf("result%0d", i), int'(resO[i]), int'(mRes[i]));
        end
    end

    int latS [3];
    int resS [3];

    task automatic doOp(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [2:0] im, input logic is);
        int cnt;
        bit seen [3];
        cnt = 0;
        seen = '{0, 0, 0};
        a = ia;
        b = ib;
        mode = im;
        sgn = is;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(seen[0] && seen[1] && seen[2]) && cnt < 40) begin
            @(negedge clk);
            cnt++;
            for (int i = 0; i < 3; i++) begin
                if (doneO[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    latS[i] = cnt;
                    resS[i] = int'(resO[i]);
                end
            end
        end
        chk("opTimeout", int'(seen[0] && seen[1] && seen[2]), 1);
    endtask

    initial begin
        int cnt;
        int pulses;
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        mode = '0;
        sgn = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstBusy", int'(busyO[0]), 0);
        chk("rstResult", int'(resO[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        doOp(8'h05, 8'h09, 3'd0, 1'b0);
        chk("leLat", latS[0], 8);
        chk("leRes", resS[0], 1);
        chk("leEarlyLat", latS[1], 5);
        chk("leNibLat", latS[2], 2);
        chk("leNibRes", resS[2], 1);
        doOp(8'h05, 8'h09, 3'd3, 1'b0);
        chk("gtRes", resS[0], 0);

        doOp(8'hFF, 8'h01, 3'd1, 1'b1);
        chk("ltSigned", resS[0], 1);
        doOp(8'hFF, 8'h01, 3'd1, 1'b0);
        chk("ltUnsigned", resS[0], 0);
        doOp(8'h80, 8'h7F, 3'd2, 1'b1);
        chk("geSignedMin", resS[0], 0);

        doOp(8'hA5, 8'hA5, 3'd4, 1'b0);
        chk("eqRes", resS[0], 1);
        chk("eqEarlyLat", latS[1], 8);
        doOp(8'hA5, 8'hA5, 3'd5, 1'b0);
        chk("neRes", resS[0], 0);
        doOp(8'hA5, 8'hA5, 3'd6, 1'b0);
        chk("rsvdRes", resS[0], 0);

        doOp(8'h80, 8'h00, 3'd3, 1'b0);
        chk("earlyMsbLat", latS[1], 1);
        chk("earlyMsbRes", resS[1], 1);
        doOp(8'h01, 8'h00, 3'd3, 1'b0);
        chk("earlyLsbLat", latS[1], 8);
        chk("earlyLsbRes", resS[1], 1);

        // Handshake: ignored mid-scan start, then back-to-back issue.
        a = 8'h05; b = 8'h09; mode = 3'd0; sgn = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            cnt++;
        end
        a = 8'h09; b = 8'h05; mode = 3'd1;
        start = 1'b1;
        @(negedge clk);
        cnt++;
        start = 1'b0;
        while (cnt < 8) begin
            @(negedge clk);
            cnt++;
            if (cnt == 7) chk("hsDoneEarly", int'(doneO[0]), 0);
        end
        chk("hsDone1", int'(doneO[0]), 1);
        chk("hsRes1", int'(resO[0]), 1);
        a = 8'h40; b = 8'h30; mode = 3'd3;
        start = 1'b1;
        @(negedge clk);
        cnt++;
        start = 1'b0;
        chk("hsBusy2", int'(busyO[0]), 1);
        while (cnt < 17) begin
            @(negedge clk);
            cnt++;
            if (cnt == 16) chk("hsDone2Early", int'(doneO[0]), 0);
        end
        chk("hsDone2", int'(doneO[0]), 1);
        chk("hsRes2", int'(resO[0]), 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a scan.
        a = 8'h05; b = 8'h09; mode = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arstBusy", int'(busyO[0]), 0);
        chk("arstDone", int'(doneO[0]), 0);
        chk("arstResult", int'(resO[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (doneO[0]) pulses++;
        end
        chk("arstNoDone", pulses, 0);

        doOp(8'h3C, 8'h3B, 3'd3, 1'b0);
        chk("nibLat", latS[2], 2);
        chk("nibRes", resS[2], 1);
        chk("nibEarlyLat", latS[1], 6);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/cmp_serial.md
# cmp_serial

Parametrised, multi-cycle magnitude comparator: next generation of the team's single-bit LE/GE comparator gates. Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, in a selectable relation mode (LE/LT/GE/GT/EQ/NE). Supports signed and unsigned operands. Uses a start/busy/done handshake so it can be driven directly by the pattern-generation and fault-simulation harnesses.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 1 and a multiple of DIGIT.
- DIGIT, 1: bits compared per cycle; N = WIDTH/DIGIT scan cycles.
- EARLY_EXIT, 0: 1 = finish on the first differing digit; 0 = always scan all N digits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A, sampled at accept edge.
- b  in  WIDTH  operand B, sampled at accept edge.
- mode  in  3  relation: 0 LE, 1 LT, 2 GE, 3 GT, 4 EQ, 5 NE, 6/7 reserved.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept edge.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse on completion.
- result  out  1  relation outcome; held until the next completion.

## Operation
- States: IDLE, SCAN.
- IDLE + start=1:
  - latch a, b, mode and sgn;
  - if sgn=1, invert the MSB of both latched operands (offset-binary), so unsigned compare gives the signed order;
  - clear the gt/lt flags, load digit counter = N, go to SCAN.
- SCAN, each cycle:
  - compare the top DIGIT bits of the A and B shift registers as unsigned values, only if gt=lt=0;
  - a_dig > b_dig sets gt; a_dig < b_dig sets lt;
  - flags are sticky once set;
  - shift both registers left by DIGIT; decrement the counter.
- SCAN exit:
  - counter reaches 0, or EARLY_EXIT=1 and a flag was set this cycle;
  - go to IDLE, pulse done, update result.
- Result from flags (eq = !gt & !lt):
  - LE = !gt; LT = lt; GE = !lt; GT = gt; EQ = eq; NE = !eq;
  - reserved modes yield 0.
- EARLY_EXIT does not change the result value, only latency. EQ/NE with equal operands always take N cycles.
- start while busy=1 is ignored. Latched operands and mode are unaffected.
- Operand and mode changes after the accept edge have no effect on the running compare.

## Timing
- Reset (async, any state): state IDLE, busy=0, done=0, result=0, flags and counter cleared. An in-flight compare is aborted with no done pulse.
- Accept edge E0 (start=1, busy=0): busy=1 after E0.
- Digit k (k = 0..N-1) is evaluated at edge E0+k+1.
- Completion edge Ec:
  - Ec = E0+N normally;
  - with EARLY_EXIT=1, Ec = E0+j+1, where j is the first differing digit.
- After Ec: busy=0, done=1 for exactly one cycle, result valid.
- Back-to-back: start=1 during the done cycle is accepted at the next edge. Minimum issue interval is N+1 cycles, or j+2 with early exit.
- Latency: N cycles from the accept edge to done visible.
- result changes only at a completion edge or reset.
- WIDTH=DIGIT (N=1) is legal: done follows one cycle after accept.

## Test plan
- Unsigned LE, WIDTH=8, DIGIT=1, a=0x05, b=0x09, mode=0, sgn=0 → busy high 8 cycles, done pulse at E0+8, result=1. Repeat with mode=3 → result=0.
- Signed vs unsigned, a=0xFF, b=0x01, mode=1 (LT):
  - sgn=1 → result=1;
  - sgn=0 → result=0;
  - a=0x80, b=0x7F, sgn=1, mode=2 → result=0.
- Equality, a=b=0xA5:
  - mode=4 → result=1; mode=5 → result=0; mode=6 → result=0;
  - with EARLY_EXIT=1, still done at E0+8.
- Early exit, EARLY_EXIT=1, a=0x80, b=0x00, mode=3 → done at E0+1, result=1. a=0x01, b=0x00 → done at E0+8.
- Handshake, WIDTH=8:
  - start pulsed at E0+3 with different operands → ignored; first result unchanged;
  - start during the done cycle → accepted, second done at E0+8+1+8.
- Reset mid-scan, rst asserted at E0+3 → busy=0, done=0, result=0 immediately (asynchronously), no done pulse later. Then DIGIT=4, WIDTH=8, a=0x3C, b=0x3B, mode=3 → done at E0+2, result=1.
